// File: rtl/tlc_pkg.sv
// Shared types and constants for the multi-approach traffic light controller.
package tlc_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    ALLRED = 2'd2,
    WALK   = 2'd3
  } state_t;

  localparam int unsigned RED_BIT = 2;
  localparam int unsigned YEL_BIT = 1;
  localparam int unsigned GRN_BIT = 0;
  localparam int unsigned LAMP_W  = 3;

  // Ceiling log2, never less than 1 so a derived vector width is always legal.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((width < 31) && ((32'd1 << width) < value)) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing each controller phase; done flags the last cycle.
module phase_timer #(
  parameter int unsigned TW      = 8,
  parameter int unsigned RST_VAL = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] count;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count - TW'(1);
    if (load) begin
      count_d = load_val;
    end
  end

  // done is registered alongside the count so it always equals (count == 1)
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= TW'(RST_VAL);
      done  <= (TW'(RST_VAL) == TW'(1));
    end else begin
      count <= count_d;
      done  <= (count_d == TW'(1));
    end
  end

endmodule

// File: rtl/multi_approach_traffic_ctrl.sv
// Round-robin N-approach traffic controller with density-based green extension,
// mandatory all-red clearance and a latched exclusive pedestrian walk phase.
module multi_approach_traffic_ctrl
  import tlc_pkg::*;
#(
  parameter int unsigned N_APPROACH = 4,
  parameter int unsigned T_GREEN    = 20,
  parameter int unsigned T_EXT      = 10,
  parameter int unsigned MAX_EXT    = 2,
  parameter int unsigned T_YELLOW   = 5,
  parameter int unsigned T_ALLRED   = 2,
  parameter int unsigned T_WALK     = 15,
  parameter int unsigned TW         = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ped_req,
  input  logic [N_APPROACH-1:0]           density,
  output logic [3*N_APPROACH-1:0]         lights,
  output logic                            ped_signal,
  output logic [clog2(N_APPROACH)-1:0]    cur_phase,
  output logic                            ped_pending
);

  localparam int unsigned PW = clog2(N_APPROACH);
  localparam int unsigned EW = clog2(MAX_EXT + 1);
  localparam int unsigned LW = LAMP_W * N_APPROACH;

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   phase_d;
  logic [PW-1:0]   next_app;
  logic [EW-1:0]   ext_q;
  logic [EW-1:0]   ext_d;
  logic            ped_d;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_done;
  logic [LW-1:0]   lights_d;

  // Lamp pattern for a given state/approach: only the owner may be non-red.
  function automatic logic [LW-1:0] lamp_decode(input state_t st, input logic [PW-1:0] ph);
    logic [LW-1:0] l;
    l = '0;
    for (int unsigned i = 0; i < N_APPROACH; i++) begin
      if ((PW'(i) == ph) && (st == GREEN)) begin
        l[LAMP_W*i + GRN_BIT] = 1'b1;
      end else if ((PW'(i) == ph) && (st == YELLOW)) begin
        l[LAMP_W*i + YEL_BIT] = 1'b1;
      end else begin
        l[LAMP_W*i + RED_BIT] = 1'b1;
      end
    end
    return l;
  endfunction

  phase_timer #(
    .TW      (TW),
    .RST_VAL (T_GREEN)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Next-state, timer reload, extension count and pedestrian latch.
  always_comb begin
    state_d  = state_q;
    phase_d  = cur_phase;
    ext_d    = ext_q;
    ped_d    = ped_pending | (ped_req & (state_q != WALK));
    tmr_load = 1'b0;
    tmr_val  = TW'(T_GREEN);
    next_app = (cur_phase == PW'(N_APPROACH - 1)) ? '0 : cur_phase + PW'(1);

    if (tmr_done) begin
      tmr_load = 1'b1;
      case (state_q)
        GREEN: begin
          if (density[cur_phase] && (ext_q < EW'(MAX_EXT))) begin
            tmr_val = TW'(T_EXT);
            ext_d   = ext_q + EW'(1);
          end else begin
            state_d = YELLOW;
            tmr_val = TW'(T_YELLOW);
          end
        end
        YELLOW: begin
          state_d = ALLRED;
          tmr_val = TW'(T_ALLRED);
        end
        ALLRED: begin
          // ped_d already folds in a request arriving on this very cycle
          if (ped_d) begin
            state_d = WALK;
            tmr_val = TW'(T_WALK);
            ped_d   = 1'b0;
          end else begin
            state_d = GREEN;
            phase_d = next_app;
            ext_d   = '0;
            tmr_val = TW'(T_GREEN);
          end
        end
        WALK: begin
          state_d = GREEN;
          phase_d = next_app;
          ext_d   = '0;
          tmr_val = TW'(T_GREEN);
        end
        default: begin
          state_d = GREEN;
          tmr_val = TW'(T_GREEN);
        end
      endcase
    end

    lights_d = lamp_decode(state_d, phase_d);
  end

  // State register; lamp outputs are registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= GREEN;
      cur_phase   <= '0;
      ext_q       <= '0;
      ped_pending <= 1'b0;
      lights      <= lamp_decode(GREEN, '0);
      ped_signal  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_phase   <= phase_d;
      ext_q       <= ext_d;
      ped_pending <= ped_d;
      lights      <= lights_d;
      ped_signal  <= (state_d == WALK);
    end
  end

endmodule

// File: doc/multi_approach_traffic_ctrl.md
Name: multi_approach_traffic_ctrl

Overview:
- Parametrised successor to the two-way NS/EW traffic light controller: N approaches served round-robin, one at a time.
- Every interval length is a parameter; green is extended per approach by a density input; a mandatory all-red clearance follows every yellow.
- Pedestrian requests are latched and served as an exclusive all-vehicle-red walk phase.
- Sits at the top of the intersection datapath, driving the lamp drivers directly.

Parameters:
- N_APPROACH, 4, number of approaches (legal range 2..8).
- T_GREEN, 20, base green length in clk cycles (>=1).
- T_EXT, 10, cycles added per green extension (>=1).
- MAX_EXT, 2, maximum extensions per green phase (0 disables extension).
- T_YELLOW, 5, yellow length in cycles (>=1).
- T_ALLRED, 2, all-red clearance length in cycles (>=1).
- T_WALK, 15, pedestrian walk length in cycles (>=1).
- TW, 8, timer width; must hold the largest T_* value.

Ports:
- clk, input, 1, single system clock.
- reset, input, 1, synchronous, active-high.
- ped_req, input, 1, pedestrian request; a 1-cycle pulse is sufficient.
- density, input, N_APPROACH, bit i = heavy traffic on approach i.
- lights, output, 3*N_APPROACH, per approach [3i+2]=red, [3i+1]=yellow, [3i]=green; exactly one bit per approach is set.
- ped_signal, output, 1, walk indication.
- cur_phase, output, clog2(N_APPROACH), index of the approach currently owning green or yellow.
- ped_pending, output, 1, a pedestrian request is latched and not yet served.

Behaviour:
- Reset: synchronous and active-high, with one clock. It has priority over everything and may be asserted mid-phase; any phase aborts immediately. Outputs are a Moore decode of registered state.
- Reset state is GREEN with cur_phase=0, timer=T_GREEN, ext_cnt=0, ped_pending=0. Approach 0 is green, all other approaches red, ped_signal=0.
- States: GREEN, YELLOW, ALLRED, WALK. Each state lasts exactly the loaded timer value in cycles. The timer decrements every cycle and the transition happens on the cycle where timer==1.
- GREEN, at timer==1:
  - If density[cur_phase]=1 and ext_cnt<MAX_EXT: stay in GREEN, reload timer=T_EXT, increment ext_cnt.
  - Otherwise go to YELLOW with timer=T_YELLOW.
  - density is sampled only on that cycle.
- YELLOW at timer==1 -> ALLRED, timer=T_ALLRED.
- ALLRED at timer==1:
  - If ped_pending (including a ped_req arriving on this same cycle): go to WALK, timer=T_WALK, clear ped_pending.
  - Otherwise go to GREEN with cur_phase=(cur_phase+1) mod N_APPROACH, timer=T_GREEN, ext_cnt=0.
- WALK at timer==1 -> GREEN on the next approach, same rule as ALLRED. WALK does not add a second all-red interval.
- Lamp decode:
  - GREEN: cur_phase approach green, all others red.
  - YELLOW: cur_phase approach yellow, all others red.
  - ALLRED and WALK: every approach red.
  - ped_signal=1 only in WALK.
- ped_req handling:
  - Any cycle outside WALK sets ped_pending.
  - During WALK, ped_req is ignored; no re-latch occurs.
  - Multiple requests before service collapse into one walk.
- Wrap-around: cur_phase goes from N_APPROACH-1 to 0. Density bits of non-active approaches are ignored.
- Invariant: at most one approach is non-red in any cycle. Green and walk never overlap.

Decomposition:
- Shared package tlc_pkg:
  - State enum {GREEN, YELLOW, ALLRED, WALK}.
  - Lamp-bit index constants RED_BIT=2, YEL_BIT=1, GRN_BIT=0.
  - A clog2 helper function.
- One sub-module, phase_timer: a loadable TW-bit down-counter with load, load_val and a done (==1) flag.
- The FSM, extension counter, pedestrian latch and lamp decode stay in the top module.

Test Plan:
All scenarios use N_APPROACH=3, T_GREEN=4, T_EXT=3, MAX_EXT=2, T_YELLOW=2, T_ALLRED=1, T_WALK=3.
1. Reset released, density=0, ped_req=0 -> approach0 green for 4 cycles, yellow 2, all-red 1. Approach1 green on cycle 7, approach2 on cycle 14, approach0 again on cycle 21 (wrap).
2. density=3'b001 held -> approach0 green for 4+3+3=10 cycles (extensions capped at 2), then yellow. density=3'b010 during approach0 green causes no extension.
3. ped_req pulsed for 1 cycle during approach0 green -> ped_pending=1 until the end of all-red. Then WALK for 3 cycles with all lights red and ped_signal=1, then approach1 green.
4. Three ped_req pulses before service, plus one pulse during WALK -> exactly one WALK phase, and ped_pending=0 after it.
5. ped_req asserted on the final ALLRED cycle -> WALK entered immediately on the next cycle.
6. reset asserted for 1 cycle mid-YELLOW on approach2 -> next cycle shows approach0 green, cur_phase=0, ped_pending=0, with full T_GREEN following.
7. Every scenario: an assertion that exactly one lamp bit is set per approach and that at most one approach is non-red in any cycle.
